// File: rtl/spatz_insn_tracker.sv
`default_nettype none
// ============================================================================
// Module   : spatz_insn_tracker
// Function : In-flight vector instruction ID allocator / retire tracker with
//            per-unit ownership, fence stalling and illegal-retire flagging.
// Revision : 1.0 - initial release
// ============================================================================
module spatz_insn_tracker #(
  parameter int NrParallelInstructions = 4,
  parameter int NrUnits                = 3,
  parameter int IdWidth                = $clog2(NrParallelInstructions),
  parameter int UnitWidth              = $clog2(NrUnits),
  localparam int CntWidth              = $clog2(NrParallelInstructions + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  input  logic [UnitWidth-1:0]         issue_unit_i,
  input  logic                         issue_fence_i,
  output logic [IdWidth-1:0]           issue_id_o,
  input  logic [NrUnits-1:0]           rsp_valid_i,
  input  logic [NrUnits*IdWidth-1:0]   rsp_id_i,
  output logic [NrParallelInstructions-1:0] inflight_o,
  output logic [NrUnits-1:0]           unit_busy_o,
  output logic [CntWidth-1:0]          count_o,
  output logic                         idle_o,
  output logic                         err_o
);

  logic [NrParallelInstructions-1:0] r_valid;
  logic [UnitWidth-1:0]              r_owner [NrParallelInstructions];
  logic [CntWidth-1:0]               r_count;
  logic                              r_err;

  logic [NrParallelInstructions-1:0] w_free;
  logic [IdWidth-1:0]                w_issue_id;
  logic                              w_issue_fire;
  logic [IdWidth-1:0]                w_rsp_id [NrUnits];
  logic [NrUnits-1:0]                w_legal;
  logic [NrUnits-1:0]                w_illegal;
  logic [NrParallelInstructions-1:0] w_clr;
  logic [NrParallelInstructions-1:0] w_set;
  logic [CntWidth-1:0]               w_retire_cnt;

  assign w_free = ~r_valid;

  // Fixed-priority encoder: lowest free index wins.
  always_comb begin
    w_issue_id = '0;
    for (int i = NrParallelInstructions - 1; i >= 0; i--) begin
      if (w_free[i]) w_issue_id = IdWidth'(i);
    end
  end

  assign idle_o        = (r_count == '0);
  assign issue_ready_o = issue_valid_i && (|w_free) && (!issue_fence_i || idle_o);
  assign issue_id_o    = w_issue_id;
  assign w_issue_fire  = issue_ready_o;

  for (genvar u = 0; u < NrUnits; u++) begin : g_rsp_id
    assign w_rsp_id[u] = rsp_id_i[u*IdWidth +: IdWidth];
  end

  // A retire is legal only for an owned, valid slot that no other unit names this cycle.
  always_comb begin
    logic collide;
    w_legal      = '0;
    w_illegal    = '0;
    w_clr        = '0;
    w_retire_cnt = '0;
    for (int u = 0; u < NrUnits; u++) begin
      collide = 1'b0;
      for (int v = 0; v < NrUnits; v++) begin
        if (v != u && rsp_valid_i[v] && (w_rsp_id[v] == w_rsp_id[u])) collide = 1'b1;
      end
      if (rsp_valid_i[u]) begin
        if (!collide && (int'(w_rsp_id[u]) < NrParallelInstructions) &&
            r_valid[w_rsp_id[u]] && (r_owner[w_rsp_id[u]] == UnitWidth'(u))) begin
          w_legal[u]          = 1'b1;
          w_clr[w_rsp_id[u]]  = 1'b1;
          w_retire_cnt        = w_retire_cnt + CntWidth'(1);
        end else begin
          w_illegal[u] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_set = '0;
    if (w_issue_fire) w_set[w_issue_id] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < NrParallelInstructions; i++) r_owner[i] <= '0;
    end else begin
      r_valid <= (r_valid & ~w_clr) | w_set;
      r_count <= r_count + CntWidth'(w_issue_fire) - w_retire_cnt;
      r_err   <= |w_illegal;
      if (w_issue_fire) r_owner[w_issue_id] <= issue_unit_i;
    end
  end

  always_comb begin
    unit_busy_o = '0;
    for (int u = 0; u < NrUnits; u++) begin
      for (int s = 0; s < NrParallelInstructions; s++) begin
        if (r_valid[s] && (r_owner[s] == UnitWidth'(u))) unit_busy_o[u] = 1'b1;
      end
    end
  end

  assign inflight_o = r_valid;
  assign count_o    = r_count;
  assign err_o      = r_err;

endmodule
`default_nettype wire
